// File: rtl/i2c_fifo_master.sv
// Write-only I2C master: a command FIFO of {addr,data} entries feeding a
// single-byte write sequencer (START, addr+W, ACK, data, ACK, STOP).
module i2c_fifo_master #(
  parameter int unsigned FIFO_DEPTH = 8,
  parameter int unsigned CLK_DIV    = 1
) (
  input  logic       clk,
  input  logic       arst,
  input  logic [7:0] data,
  input  logic [6:0] addr,
  input  logic       fifo_wr_en,
  input  logic       fifo_rd_en,
  output logic       fifo_empty,
  output logic       fifo_full,
  output logic       fsm_ready,
  output logic       i2c_sda,
  output logic       i2c_scl
);

  localparam int unsigned AW = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
  localparam int unsigned CW = AW + 1;
  localparam int unsigned DW = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;

  typedef enum logic [2:0] {
    IDLE, START, ADDR, ADDR_ACK, DATA, DATA_ACK, STOP
  } state_t;

  logic [14:0]   fifo_data_i;
  logic [14:0]   fifo_data_o;
  logic [14:0]   mem [FIFO_DEPTH];
  logic [AW-1:0] wr_ptr;
  logic [AW-1:0] rd_ptr;
  logic [CW-1:0] count;
  logic [CW-1:0] count_next;
  logic          do_push;
  logic          do_pop;

  state_t        state;
  logic [DW-1:0] div_cnt;
  logic [1:0]    phase;
  logic [2:0]    bit_idx;
  logic          tick;
  logic          bit_end;
  logic [7:0]    addr_byte;
  logic [7:0]    data_byte;

  assign fifo_data_i = {addr, data};
  // A pop is only honoured when the sequencer is idle; a pop makes room for a push when full.
  assign do_pop      = fifo_rd_en & ~fifo_empty & fsm_ready;
  assign do_push     = fifo_wr_en & (~fifo_full | do_pop);

  assign tick      = (div_cnt == DW'(CLK_DIV - 1));
  assign bit_end   = tick & (phase == 2'd3);
  assign addr_byte = {fifo_data_o[14:8], 1'b0};
  assign data_byte = fifo_data_o[7:0];

  // Occupancy after this edge, used to register exact flags.
  always_comb begin
    count_next = count;
    if (do_push && !do_pop) begin
      count_next = count + CW'(1);
    end else if (do_pop && !do_push) begin
      count_next = count - CW'(1);
    end
  end

  // FIFO storage; contents need no reset because the count guards reads.
  always_ff @(posedge clk) begin
    if (do_push) begin
      mem[wr_ptr] <= fifo_data_i;
    end
  end

  // FIFO pointers, occupancy, flags and the popped entry.
  always_ff @(posedge clk or negedge arst) begin
    if (!arst) begin
      wr_ptr      <= '0;
      rd_ptr      <= '0;
      count       <= '0;
      fifo_empty  <= 1'b1;
      fifo_full   <= 1'b0;
      fifo_data_o <= '0;
    end else begin
      if (do_push) begin
        wr_ptr <= wr_ptr + AW'(1);
      end
      if (do_pop) begin
        rd_ptr      <= rd_ptr + AW'(1);
        fifo_data_o <= mem[rd_ptr];
      end
      count      <= count_next;
      fifo_empty <= (count_next == '0);
      fifo_full  <= (count_next == CW'(FIFO_DEPTH));
    end
  end

  // Bit sequencer: quarter-period phases, SCL low in phases 0-1, high in 2-3.
  always_ff @(posedge clk or negedge arst) begin
    if (!arst) begin
      state     <= IDLE;
      div_cnt   <= '0;
      phase     <= '0;
      bit_idx   <= '0;
      fsm_ready <= 1'b1;
      i2c_scl   <= 1'b1;
      i2c_sda   <= 1'b1;
    end else begin
      if (state != IDLE) begin
        div_cnt <= tick ? '0 : div_cnt + DW'(1);
        if (tick) begin
          phase <= phase + 2'd1;
        end
      end
      if (state != IDLE && state != START && tick && phase == 2'd1) begin
        i2c_scl <= 1'b1;
      end
      case (state)
        IDLE: begin
          if (do_pop) begin
            state     <= START;
            div_cnt   <= '0;
            phase     <= '0;
            fsm_ready <= 1'b0;
            i2c_scl   <= 1'b1;
            i2c_sda   <= 1'b0;
          end
        end
        START: begin
          if (tick && phase == 2'd1) begin
            state   <= ADDR;
            phase   <= '0;
            bit_idx <= 3'd7;
            i2c_scl <= 1'b0;
            i2c_sda <= addr_byte[7];
          end
        end
        ADDR: begin
          if (bit_end) begin
            i2c_scl <= 1'b0;
            if (bit_idx == 3'd0) begin
              state   <= ADDR_ACK;
              i2c_sda <= 1'b1;
            end else begin
              bit_idx <= bit_idx - 3'd1;
              i2c_sda <= addr_byte[bit_idx - 3'd1];
            end
          end
        end
        ADDR_ACK: begin
          if (bit_end) begin
            state   <= DATA;
            bit_idx <= 3'd7;
            i2c_scl <= 1'b0;
            i2c_sda <= data_byte[7];
          end
        end
        DATA: begin
          if (bit_end) begin
            i2c_scl <= 1'b0;
            if (bit_idx == 3'd0) begin
              state   <= DATA_ACK;
              i2c_sda <= 1'b1;
            end else begin
              bit_idx <= bit_idx - 3'd1;
              i2c_sda <= data_byte[bit_idx - 3'd1];
            end
          end
        end
        DATA_ACK: begin
          if (bit_end) begin
            state   <= STOP;
            i2c_scl <= 1'b0;
            i2c_sda <= 1'b0;
          end
        end
        STOP: begin
          if (tick && phase == 2'd2) begin
            i2c_sda <= 1'b1;
          end
          if (bit_end) begin
            state     <= IDLE;
            fsm_ready <= 1'b1;
          end
        end
        default: begin
          state <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_i2c_fifo_master.sv
// Bench for i2c_fifo_master: queue/waveform model checked every cycle plus
// hand-computed expectations for the serial bytes and flag boundaries.
module tb_i2c_fifo_master;

  localparam int unsigned FIFO_DEPTH = 8;
  localparam int unsigned CLK_DIV    = 1;

  logic       clk = 1'b0;
  logic       arst = 1'b0;
  logic [7:0] data = '0;
  logic [6:0] addr = '0;
  logic       fifo_wr_en = 1'b0;
  logic       fifo_rd_en = 1'b0;
  logic       fifo_empty;
  logic       fifo_full;
  logic       fsm_ready;
  logic       i2c_sda;
  logic       i2c_scl;

  int checks = 0;
  int failures = 0;

  i2c_fifo_master #(.FIFO_DEPTH(FIFO_DEPTH), .CLK_DIV(CLK_DIV)) dut (
    .clk        (clk),
    .arst       (arst),
    .data       (data),
    .addr       (addr),
    .fifo_wr_en (fifo_wr_en),
    .fifo_rd_en (fifo_rd_en),
    .fifo_empty (fifo_empty),
    .fifo_full  (fifo_full),
    .fsm_ready  (fsm_ready),
    .i2c_sda    (i2c_sda),
    .i2c_scl    (i2c_scl)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // ---------------- behavioural model ----------------
  logic [14:0] mq[$];
  logic [1:0]  wave[$];
  logic        m_ready = 1'b1;
  logic        m_scl = 1'b1;
  logic        m_sda = 1'b1;
  logic [14:0] m_dout = '0;
  logic        m_pop;
  logic        m_push;
  logic [1:0]  w;

  task automatic add_phase(input logic scl, input logic sda);
    repeat (CLK_DIV) wave.push_back({scl, sda});
  endtask

  // Expected {scl,sda} per clk for one whole transaction.
  task automatic build_wave(input logic [14:0] e);
    logic [17:0] bits;
    bits = {e[14:8], 1'b0, 1'b1, e[7:0], 1'b1};
    add_phase(1'b1, 1'b0);
    add_phase(1'b1, 1'b0);
    for (int i = 17; i >= 0; i--) begin
      add_phase(1'b0, bits[i]);
      add_phase(1'b0, bits[i]);
      add_phase(1'b1, bits[i]);
      add_phase(1'b1, bits[i]);
    end
    add_phase(1'b0, 1'b0);
    add_phase(1'b0, 1'b0);
    add_phase(1'b1, 1'b0);
    add_phase(1'b1, 1'b1);
  endtask

  always @(posedge clk or negedge arst) begin
    if (!arst) begin
      mq.delete();
      wave.delete();
      m_ready = 1'b1;
      m_scl   = 1'b1;
      m_sda   = 1'b1;
      m_dout  = '0;
    end else begin
      m_pop  = fifo_rd_en && (mq.size() > 0) && m_ready;
      m_push = fifo_wr_en && ((mq.size() < FIFO_DEPTH) || m_pop);
      if (m_pop) begin
        m_dout = mq.pop_front();
        build_wave(m_dout);
      end
      if (m_push) mq.push_back({addr, data});
      if (wave.size() > 0) begin
        w = wave.pop_front();
        m_scl = w[1];
        m_sda = w[0];
        m_ready = 1'b0;
      end else begin
        m_scl = 1'b1;
        m_sda = 1'b1;
        m_ready = 1'b1;
      end
    end
  end

  // Compare DUT against the model every cycle, away from the active edge.
  always @(negedge clk) begin
    chk("empty", 32'(fifo_empty), 32'(mq.size() == 0));
    chk("full", 32'(fifo_full), 32'(mq.size() == FIFO_DEPTH));
    chk("ready", 32'(fsm_ready), 32'(m_ready));
    chk("scl", 32'(i2c_scl), 32'(m_scl));
    chk("sda", 32'(i2c_sda), 32'(m_sda));
    chk("data_o", 32'(dut.fifo_data_o), 32'(m_dout));
    chk("data_i", 32'(dut.fifo_data_i), 32'({addr, data}));
  end

  // Bus monitor: SDA at each SCL rise, START and STOP conditions.
  logic [31:0] cap = '0;
  int cap_n = 0, start_n = 0, stop_n = 0;
  logic prev_scl = 1'b1, prev_sda = 1'b1;
  always @(negedge clk) begin
    if (arst && i2c_scl && !prev_scl) begin
      cap = {cap[30:0], i2c_sda};
      cap_n++;
    end
    if (arst && prev_scl && i2c_scl && prev_sda && !i2c_sda) start_n++;
    if (arst && prev_scl && i2c_scl && !prev_sda && i2c_sda) stop_n++;
    prev_scl = i2c_scl;
    prev_sda = i2c_sda;
  end

  // ---------------- stimulus ----------------
  task automatic cycle();
    @(posedge clk);
    #1;
  endtask

  task automatic push(input logic [6:0] a, input logic [7:0] d);
    addr = a;
    data = d;
    fifo_wr_en = 1'b1;
    cycle();
    fifo_wr_en = 1'b0;
  endtask

  task automatic pop();
    fifo_rd_en = 1'b1;
    cycle();
    fifo_rd_en = 1'b0;
  endtask

  task automatic wait_idle(input int max_cycles);
    bit ok;
    ok = 1'b0;
    for (int i = 0; i < max_cycles; i++) begin
      cycle();
      if (fsm_ready) begin
        ok = 1'b1;
        break;
      end
    end
    chk("idle_timeout", 32'(ok), 32'd1);
  endtask

  task automatic clear_mon();
    cap = '0;
    cap_n = 0;
    start_n = 0;
    stop_n = 0;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: bench did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    // Reset state
    cycle();
    cycle();
    chk("rst_empty", 32'(fifo_empty), 32'd1);
    chk("rst_full", 32'(fifo_full), 32'd0);
    chk("rst_ready", 32'(fsm_ready), 32'd1);
    chk("rst_scl", 32'(i2c_scl), 32'd1);
    chk("rst_sda", 32'(i2c_sda), 32'd1);
    arst = 1'b1;
    cycle();

    // Single write {0x50,0xA5}
    push(7'h50, 8'hA5);
    clear_mon();
    pop();
    chk("t2_data_o", 32'(dut.fifo_data_o), 32'h50A5);
    chk("t2_ready", 32'(fsm_ready), 32'd0);
    wait_idle(200 * CLK_DIV);
    chk("t2_bits", 32'(cap[18:1]), 32'(18'b10_1000_0011_0100_1011));
    chk("t2_stopbit", 32'(cap[0]), 32'd0);
    chk("t2_rises", 32'(cap_n), 32'd19);
    chk("t2_start", 32'(start_n), 32'd1);
    chk("t2_stop", 32'(stop_n), 32'd1);

    // Pop on empty FIFO is ignored
    fifo_rd_en = 1'b1;
    repeat (3) cycle();
    fifo_rd_en = 1'b0;
    chk("t4_ready", 32'(fsm_ready), 32'd1);
    chk("t4_scl", 32'(i2c_scl), 32'd1);
    chk("t4_sda", 32'(i2c_sda), 32'd1);
    chk("t4_empty", 32'(fifo_empty), 32'd1);

    // Pop while busy is ignored; order preserved
    push(7'h12, 8'h34);
    push(7'h7F, 8'hFF);
    pop();
    chk("t5_first", 32'(dut.fifo_data_o), 32'h1234);
    repeat (5) cycle();
    pop();
    chk("t5_kept", 32'(dut.fifo_data_o), 32'h1234);
    wait_idle(200 * CLK_DIV);
    chk("t5_not_empty", 32'(fifo_empty), 32'd0);
    clear_mon();
    pop();
    chk("t5_second", 32'(dut.fifo_data_o), 32'h7FFF);
    chk("t5_empty", 32'(fifo_empty), 32'd1);
    wait_idle(200 * CLK_DIV);
    chk("t5_bits", 32'(cap[18:1]), 32'(18'b11_1111_1011_1111_1111));

    // Fill to full, drop extra push, pop frees a slot
    for (int i = 0; i < FIFO_DEPTH; i++) begin
      push(7'(i + 1), 8'(8'h10 + i));
    end
    chk("t3_full", 32'(fifo_full), 32'd1);
    push(7'h55, 8'h55);
    chk("t3_full_drop", 32'(fifo_full), 32'd1);
    pop();
    chk("t3_full_clr", 32'(fifo_full), 32'd0);
    chk("t3_head", 32'(dut.fifo_data_o), 32'h0110);

    // Reset in the middle of the data byte
    repeat (48 * CLK_DIV) cycle();
    arst = 1'b0;
    #1;
    chk("t6_scl", 32'(i2c_scl), 32'd1);
    chk("t6_sda", 32'(i2c_sda), 32'd1);
    chk("t6_ready", 32'(fsm_ready), 32'd1);
    chk("t6_empty", 32'(fifo_empty), 32'd1);
    chk("t6_full", 32'(fifo_full), 32'd0);
    cycle();
    arst = 1'b1;
    repeat (4) cycle();
    chk("t6_idle_scl", 32'(i2c_scl), 32'd1);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
